spsram_doubled: RTL and testbench

SPSRAM_DOUBLED -- requirements
Module: spsram_doubled

---
 rtl/spsram_doubled.sv | 86 ++++++++
 tb/tb_spsram_doubled.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/spsram_doubled.sv
// Single-port SRAM built from two half-width banks sharing address and control.
// Read data is registered per bank and gated onto o_data by i_oen.
module spsram_bank #(
  parameter int BWIDTH = 16,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              wen,
  input  logic [AWIDTH-1:0] addr,
  input  logic [BWIDTH-1:0] wdata,
  output logic [BWIDTH-1:0] rdata
);

  logic [BWIDTH-1:0] mem [DEPTH];

  // Reset clears the whole array so no stale data survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else if (cen) begin
      if (wen) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

module spsram_doubled #(
  parameter int DWIDTH = 32,
  parameter int BWIDTH = 16,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DWIDTH-1:0] i_data,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic              i_cen,
  input  logic              i_wen,
  input  logic              i_oen,
  output logic [DWIDTH-1:0] o_data
);

  logic [BWIDTH-1:0] rd_l;
  logic [BWIDTH-1:0] rd_h;

  spsram_bank #(
    .BWIDTH (BWIDTH),
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_bank_l (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .cen   (i_cen),
    .wen   (i_wen),
    .addr  (i_addr),
    .wdata (i_data[BWIDTH-1:0]),
    .rdata (rd_l)
  );

  spsram_bank #(
    .BWIDTH (BWIDTH),
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_bank_h (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .cen   (i_cen),
    .wen   (i_wen),
    .addr  (i_addr),
    .wdata (i_data[DWIDTH-1:BWIDTH]),
    .rdata (rd_h)
  );

  assign o_data = i_oen ? {rd_h, rd_l} : '0;

endmodule

// File: tb/tb_spsram_doubled.sv
// Randomised and directed bench for spsram_doubled.
// A flat array model tracks memory and the last read word.
module tb_spsram_doubled;

  logic        i_clk;
  logic        i_rstn;
  logic [31:0] i_data;
  logic [4:0]  i_addr;
  logic        i_cen;
  logic        i_wen;
  logic        i_oen;
  logic [31:0] o_data;

  int checks;
  int errors;

  logic [31:0] m_mem [32];
  logic [31:0] m_rd;

  spsram_doubled dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_data (i_data),
    .i_addr (i_addr),
    .i_cen  (i_cen),
    .i_wen  (i_wen),
    .i_oen  (i_oen),
    .o_data (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_out(input logic oen);
    return oen ? m_rd : 32'h0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_rd = '0;
  endtask

  // drive at negedge, step the model at posedge, compare 1ns later
  task automatic cyc(input logic cen, input logic wen, input logic oen,
                     input logic [4:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_cen  = cen;
    i_wen  = wen;
    i_oen  = oen;
    i_addr = a;
    i_data = d;
    @(posedge i_clk);
    if (cen && wen) m_mem[a] = d;
    else if (cen) m_rd = m_mem[a];
    #1;
    chk("cyc", o_data, m_out(oen));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] exp;
    logic [4:0]  a;
    checks = 0;
    errors = 0;
    i_rstn = 1'b0;
    i_cen  = 1'b0;
    i_wen  = 1'b0;
    i_oen  = 1'b1;
    i_addr = '0;
    i_data = '0;
    m_clear();
    #12;
    chk("rst_out", o_data, 32'h0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    cyc(1'b1, 1'b0, 1'b1, 5'd5, 32'h0);
    chk("rd_after_rst", o_data, 32'h0);

    cyc(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 1'b1, 5'd3, 32'h0);
    chk("b2b_rd", o_data, 32'hDEADBEEF);
    @(negedge i_clk);
    i_oen = 1'b0;
    #1;
    chk("oen_gate", o_data, 32'h0);

    cyc(1'b1, 1'b1, 1'b1, 5'd31, 32'hAAAA5555);
    cyc(1'b1, 1'b0, 1'b1, 5'd31, 32'h0);
    chk("bank_l", {16'h0, o_data[15:0]}, 32'h5555);
    chk("bank_h", {16'h0, o_data[31:16]}, 32'hAAAA);

    for (int i = 0; i < 100; i++) begin
      a = 5'(i);
      cyc(1'b1, 1'b1, 1'b1, a, 32'(i));
    end
    for (int k = 0; k < 100; k++) begin
      a = 5'(k);
      exp = ((k % 32) < 4) ? 32'(96 + k % 32) : 32'(64 + k % 32);
      cyc(1'b1, 1'b0, 1'b1, a, 32'h0);
      chk("wrap", o_data, exp);
    end

    cyc(1'b1, 1'b1, 1'b1, 5'd1, 32'h11);
    cyc(1'b1, 1'b0, 1'b1, 5'd1, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 5'd2, 32'h22);
    chk("wr_hold", o_data, 32'h11);
    cyc(1'b1, 1'b0, 1'b1, 5'd2, 32'h0);
    chk("rd_new", o_data, 32'h22);

    cyc(1'b0, 1'b1, 1'b1, 5'd2, 32'h99);
    chk("cen_off", o_data, 32'h22);
    cyc(1'b1, 1'b0, 1'b1, 5'd2, 32'h0);
    chk("cen_off_mem", o_data, 32'h22);

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
          5'($urandom), $urandom);
    end

    cyc(1'b1, 1'b0, 1'b1, 5'd3, 32'h0);
    #2;
    i_rstn = 1'b0;
    m_clear();
    #1;
    chk("mid_rst", o_data, 32'h0);
    @(posedge i_clk);
    #1;
    chk("rst_hold", o_data, 32'h0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      cyc(1'b1, 1'b0, 1'b1, a, 32'h0);
      chk("rst_clear", o_data, 32'h0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
